// File: rtl/shift_pkg.sv
// Shared constants for the serial shift transmitter.
package shift_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_counter.sv
// Bit-position counter for the serializer. It saturates at WIDTH-1 and
// never wraps; the owner clears it explicitly when a word ends.
module bit_counter #(
  parameter int WIDTH = shift_pkg::DEFAULT_WIDTH,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  assign terminal = (count == LAST);

  // Clear has priority; increment stops at the last bit position.
  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (en && !terminal)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/serial_shift_tx.sv
// Parallel-to-serial transmitter, LSB first, with a ready/valid load side
// and a stallable shift side. A new word can be taken on the last-bit cycle
// so consecutive words stream with no gap bit.
module serial_shift_tx
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             terminal;
  logic             in_shift;
  logic             word_done;
  logic             accept;

  assign in_shift   = (state_q == SHIFT);
  assign word_done  = in_shift && terminal && shift_en;
  assign load_ready = !rst && (!in_shift || word_done);
  assign accept     = load_valid && load_ready;

  assign out_valid  = in_shift;
  assign out_bit    = in_shift && sreg[0];
  assign out_last   = in_shift && terminal;

  bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept || word_done),
    .en       (in_shift && shift_en),
    .count    (cnt),
    .terminal (terminal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: enter SHIFT on accept, leave only when the last bit goes out
  // and no follow-on word is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (word_done) state_d = accept ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift register: load on accept, otherwise shift right with zero fill.
  always_ff @(posedge clk) begin
    if (rst)
      sreg <= '0;
    else if (accept)
      sreg <= load_data;
    else if (in_shift && shift_en)
      sreg <= {1'b0, sreg[WIDTH-1:1]};
  end

endmodule

// File: tb/tb_serial_shift_tx.sv
// Scoreboard bench for serial_shift_tx (WIDTH=4): stimulus pushes expected
// bits, a negedge monitor pops them and runs a loopback receiver.
module tb_serial_shift_tx;

  localparam int W = 4;

  typedef struct {
    logic         b;
    logic         last;
    logic [W-1:0] word;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_ready;
  logic         shift_en = 1'b1;
  logic         out_bit, out_valid, out_last;

  exp_t         exp_q[$];
  logic [W-1:0] rx = '0;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           acc_cyc = 0;

  serial_shift_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .shift_en   (shift_en),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  // Monitor: every consumed bit is compared against the scoreboard, and a
  // serial-in receiver (input enters the MSB) rebuilds the word.
  always @(negedge clk) begin
    if (out_valid && shift_en) begin
      logic [W-1:0] rx_n;
      rx_n = {out_bit, rx[W-1:1]};
      if (exp_q.size() == 0) begin
        chk("unexpected_bit", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_bit", out_bit, e.b);
        chk("out_last", out_last, e.last);
        if (out_last) chk("loopback_word", rx_n, e.word);
      end
      rx <= rx_n;
    end
  end

  task automatic expect_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      exp_t e;
      e.b = w[i]; e.last = (i == W - 1); e.word = w;
      exp_q.push_back(e);
    end
  endtask

  // Offer a word and wait (bounded) for the accepting edge; returns at edge+#1.
  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    load_valid = 1'b1;
    load_data  = w;
    do begin
      @(negedge clk);
      n++;
    end while (!load_ready && n < 50);
    chk("load_ready_timeout", load_ready, 1);
    expect_word(w);
    @(posedge clk);
    acc_cyc = cyc;
    #1 load_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", (n < 100), 1);
  endtask

  int first_acc;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_load_ready", load_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    #1;
    chk("idle_out_bit", out_bit, 0);
    chk("idle_out_last", out_last, 0);
    chk("idle_load_ready", load_ready, 1);

    // Single word 1011 -> 1,1,0,1 then IDLE
    send(4'b1011);
    drain();
    chk("single_back_idle", out_valid, 0);
    chk("single_ready", load_ready, 1);

    // Back-to-back 0001 then 1110, accepts four cycles apart (no gap)
    send(4'b0001);
    first_acc = acc_cyc;
    send(4'b1110);
    chk("b2b_accept_spacing", acc_cyc - first_acc, 4);
    drain();

    // Stall: 0110, hold shift_en low three cycles after bit 1 appears
    send(4'b0110);
    @(posedge clk); #1;
    shift_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_bit", out_bit, 1);
      chk("stall_valid", out_valid, 1);
      chk("stall_ready", load_ready, 0);
    end
    @(posedge clk); #1;
    shift_en = 1'b1;
    drain();

    // Reset mid-word: 1111, reset while the second bit is on the line
    send(4'b1111);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_bit", out_bit, 0);
    chk("midrst_out_last", out_last, 0);
    chk("midrst_load_ready", load_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_idle", out_valid, 0);
    send(4'b1010);
    drain();

    // Ignored load: junk offered while busy must not disturb the word
    send(4'b1001);
    load_valid = 1'b1;
    load_data  = 4'b0110;
    @(negedge clk);
    chk("busy_ready_low", load_ready, 0);
    @(posedge clk); #1;
    load_data  = 4'b1111;
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_data  = 4'b0000;
    drain();

    // Loopback with random words, some streamed back-to-back
    for (int i = 0; i < 6; i++) send(4'($urandom_range(0, 15)));
    drain();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
